// File: rtl/controlador_display_7seg_multiplexado.sv
// Time-multiplexed 7-segment driver for N hex digits with guard interval and frame-coherent snapshot.
// Optional leading-zero suppression is enabled by defining SUPRIMIR_CEROS_EN.
module controlador_display_7seg_multiplexado #(
    parameter int N_DIGITOS         = 4,
    parameter int DIV_REFRESCO      = 50000,
    parameter int GUARDA            = 2,
    parameter int ANODO_ACTIVO_BAJO = 1,
    parameter int SEG_ACTIVO_BAJO   = 1
) (
    input  logic                   i_Reloj,
    input  logic                   i_Reset,
    input  logic [4*N_DIGITOS-1:0] i_Datos,
    input  logic [N_DIGITOS-1:0]   i_Punto,
    input  logic                   i_Habilitar,
    output logic [6:0]             o_Segmentos,
    output logic                   o_Punto,
    output logic [N_DIGITOS-1:0]   o_Anodos,
    output logic                   o_Fin_Cuadro
);

    localparam int CNT_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

    if (N_DIGITOS < 1 || N_DIGITOS > 8 || GUARDA < 1 || DIV_REFRESCO < GUARDA + 2) begin : g_param_err
        $error("controlador_display_7seg_multiplexado: illegal parameter combination");
    end

    function automatic logic [6:0] hex_a_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*N_DIGITOS-1:0] snap_datos_q, snap_datos_d;
    logic [N_DIGITOS-1:0]   snap_punto_q, snap_punto_d;
    // Output registers hold active-high values; polarity is applied at the pins.
    logic [N_DIGITOS-1:0]   anod_q, anod_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic                   fin_q, fin_d;

    logic                   inicio_cuadro;
    logic                   visible;
    logic [3:0]             nibble;
    logic                   punto_sel;
    logic [N_DIGITOS-1:0]   suprimido;

    always_comb begin
        inicio_cuadro = i_Habilitar && (cnt_q == '0) && (idx_q == '0);
        visible       = i_Habilitar && (cnt_q >= CNT_W'(GUARDA));
        nibble        = snap_datos_q[{idx_q, 2'b00} +: 4];
        punto_sel     = snap_punto_q[idx_q];
    end

    always_comb begin
        logic todo_cero;
        todo_cero = 1'b1;
        suprimido = '0;
        for (int d = N_DIGITOS - 1; d >= 0; d--) begin
            todo_cero    = todo_cero && (snap_datos_q[4*d +: 4] == 4'h0);
            suprimido[d] = (d > 0) && todo_cero;
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_datos_d = snap_datos_q;
        snap_punto_d = snap_punto_q;
        fin_d        = inicio_cuadro;

        if (!i_Habilitar) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_W'(DIV_REFRESCO - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(N_DIGITOS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (inicio_cuadro) begin
            snap_datos_d = i_Datos;
            snap_punto_d = i_Punto;
        end
    end

    always_comb begin
        anod_d = '0;
        seg_d  = '0;
        dp_d   = 1'b0;
        if (visible) begin
`ifdef SUPRIMIR_CEROS_EN
            if (suprimido[idx_q]) begin
                // A suppressed digit stays dark unless its decimal point is requested.
                if (punto_sel) begin
                    anod_d[idx_q] = 1'b1;
                    dp_d          = 1'b1;
                end
            end else begin
                anod_d[idx_q] = 1'b1;
                seg_d         = hex_a_seg(nibble);
                dp_d          = punto_sel;
            end
`else
            anod_d[idx_q] = 1'b1;
            seg_d         = hex_a_seg(nibble);
            dp_d          = punto_sel;
`endif
        end
    end

    always_ff @(posedge i_Reloj or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_datos_q <= '0;
            snap_punto_q <= '0;
            anod_q       <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            fin_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_datos_q <= snap_datos_d;
            snap_punto_q <= snap_punto_d;
            anod_q       <= anod_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            fin_q        <= fin_d;
        end
    end

    assign o_Anodos     = (ANODO_ACTIVO_BAJO != 0) ? ~anod_q : anod_q;
    assign o_Segmentos  = (SEG_ACTIVO_BAJO != 0) ? ~seg_q : seg_q;
    assign o_Punto      = (SEG_ACTIVO_BAJO != 0) ? ~dp_q : dp_q;
    assign o_Fin_Cuadro = fin_q;

endmodule

// File: tb/tb_controlador_display_7seg_multiplexado.sv
// Scoreboard bench: a position-based frame model predicts each cycle's pins; a monitor compares.
module tb_controlador_display_7seg_multiplexado;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int G   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   datos = '0;
    logic [3:0]    punto = '0;
    logic          hab = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          fin;

    controlador_display_7seg_multiplexado #(
        .N_DIGITOS(N), .DIV_REFRESCO(DIV), .GUARDA(G),
        .ANODO_ACTIVO_BAJO(1), .SEG_ACTIVO_BAJO(1)
    ) dut (
        .i_Reloj(clk), .i_Reset(rst), .i_Datos(datos), .i_Punto(punto),
        .i_Habilitar(hab), .o_Segmentos(seg), .o_Punto(dp), .o_Anodos(an),
        .o_Fin_Cuadro(fin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fin;
    } pins_t;

    localparam pins_t BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fin: 1'b0};

    pins_t      sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] tabla [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: enabled cycles since the scan (re)started, and the frame snapshot.
    int          pos = 0;
    logic [15:0] m_datos = '0;
    logic [3:0]  m_punto = '0;
    int          edge_n = 0;

    function automatic pins_t digito(input int slot, input logic [15:0] d, input logic [3:0] p);
        pins_t e;
        logic [3:0] nib;
        logic [3:0] one;
        bit sup;
        e   = BLANK;
        nib = d[4*slot +: 4];
        one = 4'b0001 << slot;
        sup = 1'b0;
`ifdef SUPRIMIR_CEROS_EN
        sup = (slot > 0) && ((d >> (4*slot)) == 16'h0);
`endif
        if (!sup) begin
            e.an  = ~one;
            e.seg = ~tabla[nib];
            e.dp  = ~p[slot];
        end else if (p[slot]) begin
            e.an = ~one;
            e.dp = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nombre, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and push the expected post-edge pins.
    task automatic step(input logic [15:0] d, input logic [3:0] p, input logic en, input logic rs);
        pins_t e;
        @(negedge clk);
        datos = d; punto = p; hab = en; rst = rs;
        e = BLANK;
        if (rs) begin
            pos = 0; m_datos = '0; m_punto = '0;
        end else if (!en) begin
            pos = 0;
        end else begin
            if ((pos % DIV) >= G) e = digito((pos / DIV) % N, m_datos, m_punto);
            if ((pos % (N*DIV)) == 0) begin
                e.fin = 1'b1;
                m_datos = d; m_punto = p;
            end
            pos++;
        end
        sb_q.push_back(e);
    endtask

    initial begin
        pins_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                edge_n++;
                e = sb_q.pop_front();
                if ({an, seg, dp, fin} !== e) begin
                    n_err++;
                    $display("FAIL pins edge %0d: got an=%b seg=%b dp=%b fin=%b expected an=%b seg=%b dp=%b fin=%b",
                             edge_n, an, seg, dp, fin, e.an, e.seg, e.dp, e.fin);
                end
                n_cmp++;
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  p;
        logic        en;
        int          apag;
        #23;
        chk("reset_anodos", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_fin", 32'(fin), 32'h0);

        // Directed frame: 4321, switching to FFFF before edge 12 to show frame coherence.
        for (int k = 1; k <= 70; k++)
            step((k >= 12) ? 16'hFFFF : 16'h4321, 4'b0000, 1'b1, 1'b0);

        // Enable drop mid-frame and re-assert.
        for (int k = 0; k < 5; k++) step(16'h1234, 4'b0101, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step(16'h1234, 4'b0101, 1'b1, 1'b0);

        // Asynchronous reset mid-slot: pins must go inactive with no clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_anodos", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_dp", 32'(dp), 32'h1);
        chk("async_rst_fin", 32'(fin), 32'h0);
        step(16'h1234, 4'b0101, 1'b1, 1'b1);

        // Suppression-oriented pattern followed by randomized operation.
        for (int k = 0; k < 40; k++) step(16'h0050, 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) step(16'h0050, 4'b1000, 1'b1, 1'b0);

        d = 16'h0; p = 4'h0; en = 1'b1; apag = 0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int j = 0; j < 4; j++)
                    d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                p = 4'($urandom);
            end
            if (apag > 0) begin
                apag--;
                en = (apag == 0);
            end else if ($urandom_range(0, 99) == 0) begin
                apag = $urandom_range(1, 12);
                en = 1'b0;
            end
            step(d, p, en, 1'b0);
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
